// File: rtl/imem_loader.sv
// Serial byte-stream loader for the instruction memory: 16-bit word count, big-endian words,
// trailing XOR checksum. Holds the CPU in reset while a load is active or has failed.
module imem_loader #(
   parameter int unsigned MEM_AW  = 12,
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int unsigned     MaxWords = 2 ** MEM_AW;
   localparam int unsigned     TmoW     = $clog2(TIMEOUT);
   // Compare against TIMEOUT-2 so the counter value after this edge equals TIMEOUT-1.
   localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT - 2);

   typedef enum logic [2:0] {
      StIdle, StHdrHi, StHdrLo, StData, StCsum, StDone, StErr
   } state_e;

   state_e            state_q;
   logic [15:0]       count_q;
   logic [MEM_AW-1:0] word_idx_q;
   logic [1:0]        byte_idx_q;
   logic [23:0]       word_q;
   logic [7:0]        csum_q;
   logic [TmoW-1:0]   tmo_q;
   logic              mem_we_q;
   logic [MEM_AW-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              cpu_rst_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [1:0]        err_code_q;

   logic        accept;
   logic [15:0] hdr_cnt;
   logic        last_word;

   always_comb begin
      rx_ready = 1'b0;
      case (state_q)
         StHdrHi, StHdrLo, StData, StCsum: rx_ready = 1'b1;
         default:                          rx_ready = 1'b0;
      endcase
   end

   assign accept    = rx_valid && rx_ready;
   assign hdr_cnt   = {count_q[15:8], rx_data};
   assign last_word = (32'(word_idx_q) + 32'd1) == 32'(count_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         count_q     <= '0;
         word_idx_q  <= '0;
         byte_idx_q  <= '0;
         word_q      <= '0;
         csum_q      <= '0;
         tmo_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'd0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            StIdle, StDone, StErr: begin
               if (start) begin
                  state_q    <= StHdrHi;
                  busy_q     <= 1'b1;
                  cpu_rst_q  <= 1'b1;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  err_code_q <= 2'd0;
                  word_idx_q <= '0;
                  byte_idx_q <= '0;
                  csum_q     <= '0;
                  tmo_q      <= '0;
               end
            end
            StHdrHi, StHdrLo, StData, StCsum: begin
               if (accept) begin
                  tmo_q <= '0;
                  case (state_q)
                     StHdrHi: begin
                        count_q[15:8] <= rx_data;
                        state_q       <= StHdrLo;
                     end
                     StHdrLo: begin
                        count_q[7:0] <= rx_data;
                        if (hdr_cnt == 16'd0 || 32'(hdr_cnt) > MaxWords) begin
                           state_q    <= StErr;
                           busy_q     <= 1'b0;
                           err_q      <= 1'b1;
                           err_code_q <= 2'd1;
                        end else begin
                           state_q <= StData;
                        end
                     end
                     StData: begin
                        word_q     <= {word_q[15:0], rx_data};
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                           mem_we_q    <= 1'b1;
                           mem_addr_q  <= word_idx_q;
                           mem_wdata_q <= {word_q, rx_data};
                           word_idx_q  <= word_idx_q + 1'b1;
                           if (last_word) state_q <= StCsum;
                        end
                     end
                     StCsum: begin
                        busy_q <= 1'b0;
                        if (rx_data == csum_q) begin
                           state_q   <= StDone;
                           done_q    <= 1'b1;
                           cpu_rst_q <= 1'b0;
                        end else begin
                           state_q    <= StErr;
                           err_q      <= 1'b1;
                           err_code_q <= 2'd2;
                        end
                     end
                     default: state_q <= StIdle;
                  endcase
               end else if (tmo_q == TmoLast) begin
                  state_q    <= StErr;
                  busy_q     <= 1'b0;
                  err_q      <= 1'b1;
                  err_code_q <= 2'd3;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, header/checksum/timeout errors, throttled input
// and asynchronous reset mid-load.
module tb_imem_loader;

   localparam int unsigned MEM_AW  = 12;
   localparam int unsigned TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              err;
   logic [1:0]        err_code;

   // {busy, done, err, err_code, cpu_rst}
   logic [5:0] status;
   assign status = {busy, done, err, err_code, cpu_rst};

   int total = 0;
   int bad   = 0;

   logic [7:0]        stream[$];
   logic [MEM_AW-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];

   imem_loader #(
      .MEM_AW  (MEM_AW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_rst   (cpu_rst),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   // Send the queued bytes; gap idle cycles with rx_valid low after each accepted byte.
   task automatic send_buf(input int gap);
      int waited;
      for (int i = 0; i < stream.size(); i++) begin
         waited   = 0;
         rx_valid = 1'b1;
         rx_data  = stream[i];
         while (!rx_ready && waited < 20) begin
            tick();
            waited++;
         end
         if (!rx_ready) begin
            $display("FAIL send_byte: rx_ready=%b after %0d cycles, required 1", rx_ready, waited);
            bad++;
            total++;
            rx_valid = 1'b0;
            stream.delete();
            return;
         end
         tick();
         rx_valid = 1'b0;
         repeat (gap) tick();
      end
      stream.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (3) tick();
      if ({rx_ready, mem_we, mem_addr, mem_wdata, status} !== '0) begin
         $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h data=%h st=%b, required all 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, status);
         bad++;
      end
      total++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      clear_log();
      pulse_start();
      if (status !== 6'b100001) begin
         $display("FAIL basic_busy: status=%b required 100001", status); bad++;
      end
      total++;
      stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h22};
      send_buf(0);
      if (status !== 6'b010000) begin
         $display("FAIL basic_done: status=%b required 010000", status); bad++;
      end
      total++;
      tick();
      if (wr_addr.size() !== 2) begin
         $display("FAIL basic_nwr: writes=%0d required 2", wr_addr.size()); bad++;
      end
      total++;
      if (wr_addr.size() >= 2) begin
         if (wr_addr[0] !== 12'd0 || wr_data[0] !== 32'hDEADBEEF) begin
            $display("FAIL basic_w0: %h@%h required DEADBEEF@000", wr_data[0], wr_addr[0]); bad++;
         end
         total++;
         if (wr_addr[1] !== 12'd1 || wr_data[1] !== 32'h01234567) begin
            $display("FAIL basic_w1: %h@%h required 01234567@001", wr_data[1], wr_addr[1]); bad++;
         end
         total++;
      end
   endtask

   task automatic test_bad_count();
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h00};
      send_buf(0);
      if (status !== 6'b001011) begin
         $display("FAIL count_zero: status=%b required 001011", status); bad++;
      end
      total++;
      pulse_start();
      stream = '{8'h10, 8'h01};
      send_buf(0);
      if (status !== 6'b001011) begin
         $display("FAIL count_4097: status=%b required 001011", status); bad++;
      end
      total++;
      tick();
      if (wr_addr.size() !== 0) begin
         $display("FAIL count_nwr: writes=%0d required 0", wr_addr.size()); bad++;
      end
      total++;
   endtask

   task automatic test_bad_csum();
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
      send_buf(0);
      if (status !== 6'b001101) begin
         $display("FAIL csum_err: status=%b required 001101", status); bad++;
      end
      total++;
      if (wr_addr.size() !== 1 || wr_data[0] !== 32'h11223344 || wr_addr[0] !== 12'd0) begin
         $display("FAIL csum_wr: n=%0d data=%h required 1 write 11223344@000",
                  wr_addr.size(), wr_data[0]);
         bad++;
      end
      total++;
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
      send_buf(0);
      if (status !== 6'b010000) begin
         $display("FAIL csum_reload: status=%b required 010000", status); bad++;
      end
      total++;
      if (wr_addr.size() !== 1 || wr_data[0] !== 32'hCAFEBABE || wr_addr[0] !== 12'd0) begin
         $display("FAIL csum_reload_wr: n=%0d data=%h required 1 write CAFEBABE@000",
                  wr_addr.size(), wr_data[0]);
         bad++;
      end
      total++;
   endtask

   task automatic test_timeout();
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h01, 8'hAA};
      send_buf(0);
      repeat (14) tick();
      if (status !== 6'b100001) begin
         $display("FAIL tmo_early: status=%b after 14 idle, required 100001", status); bad++;
      end
      total++;
      tick();
      if (status !== 6'b001111) begin
         $display("FAIL tmo_fire: status=%b after 15 idle, required 001111", status); bad++;
      end
      total++;
      if (wr_addr.size() !== 0) begin
         $display("FAIL tmo_nwr: writes=%0d required 0", wr_addr.size()); bad++;
      end
      total++;
   endtask

   task automatic test_toggle();
      logic [31:0] exp_d [3];
      exp_d = '{32'h01020304, 32'h10203040, 32'hA55A0FF0};
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20};
      send_buf(1);
      pulse_start();
      if (status !== 6'b100001) begin
         $display("FAIL toggle_start_ign: status=%b required 100001", status); bad++;
      end
      total++;
      stream = '{8'h30, 8'h40, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h44};
      send_buf(1);
      if (status !== 6'b010000) begin
         $display("FAIL toggle_done: status=%b required 010000", status); bad++;
      end
      total++;
      if (wr_addr.size() !== 3) begin
         $display("FAIL toggle_nwr: writes=%0d required 3", wr_addr.size()); bad++;
      end
      total++;
      for (int i = 0; i < 3; i++) begin
         if (i < wr_addr.size()) begin
            if (wr_addr[i] !== 12'(i) || wr_data[i] !== exp_d[i]) begin
               $display("FAIL toggle_w%0d: %h@%h required %h@%h", i, wr_data[i], wr_addr[i],
                        exp_d[i], 12'(i));
               bad++;
            end
            total++;
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h11, 8'h11};
      send_buf(0);
      tick();
      tick();
      if (wr_addr.size() !== 1) begin
         $display("FAIL rmid_nwr: writes=%0d required 1", wr_addr.size()); bad++;
      end
      total++;
      #2 rst = 1'b1;
      #1;
      if ({rx_ready, mem_we, mem_addr, mem_wdata, status} !== '0) begin
         $display("FAIL rmid_async: rdy=%b we=%b addr=%h data=%h st=%b, required all 0",
                  rx_ready, mem_we, mem_addr, mem_wdata, status);
         bad++;
      end
      total++;
      tick();
      rst = 1'b0;
      tick();
      clear_log();
      pulse_start();
      stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
      send_buf(0);
      if (status !== 6'b010000) begin
         $display("FAIL rmid_reload: status=%b required 010000", status); bad++;
      end
      total++;
      if (wr_addr.size() !== 1 || wr_data[0] !== 32'h12345678 || wr_addr[0] !== 12'd0) begin
         $display("FAIL rmid_reload_wr: n=%0d data=%h required 1 write 12345678@000",
                  wr_addr.size(), wr_data[0]);
         bad++;
      end
      total++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_count();
      test_bad_csum();
      test_timeout();
      test_toggle();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Serial program loader that writes the CPU's 4096x32 instruction memory from a byte stream, the write-side counterpart of the fetch stage's read port. It holds the CPU in reset while loading, assembles big-endian 32-bit words, writes one word per 4 accepted bytes, and verifies an XOR checksum. It sits between a byte source (UART RX or test host) and the instruction memory write port / CPU reset input.

Parameters:
MEM_AW, 12, instruction memory address width; max words = 2**MEM_AW
TIMEOUT, 1000000, max idle cycles between accepted bytes while loading; must be >= 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse that begins a load
rx_valid  input  1  byte available
rx_data  input  8  byte value
rx_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable
mem_addr  output  MEM_AW  word write address
mem_wdata  output  32  word write data
cpu_rst  output  1  holds the CPU in reset while a load is active or has failed
busy  output  1  load in progress
done  output  1  last load completed OK
err  output  1  last load failed
err_code  output  2  1=bad count, 2=checksum mismatch, 3=timeout, 0=none

Behaviour:
- One clock; reset is asynchronous and active-high. All outputs are registered except rx_ready, which is decoded from the state.
- Reset: state IDLE; rx_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 0, busy 0, done 0, err 0, err_code 0. The CPU runs its preloaded image.
- A byte is accepted when rx_valid && rx_ready. rx_ready=1 only in HDR_HI, HDR_LO, DATA and CSUM.
- Stream format: count N as 2 bytes, MSB first. Then 4*N data bytes, each word MSB first. Then 1 checksum byte equal to the XOR of all 4*N data bytes.
- FSM states: IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + start -> HDR_HI. Next cycle: busy=1, cpu_rst=1, done=0, err=0, err_code=0. The word index, byte index and XOR accumulator clear to 0.
- start while in HDR_HI, HDR_LO, DATA or CSUM: ignored.
- HDR_HI: accept byte -> count[15:8], go to HDR_LO.
- HDR_LO: accept byte -> count[7:0].
  - Count 0 or count > 2**MEM_AW -> ERR with err_code=1.
  - Otherwise -> DATA.
- DATA: each accepted byte shifts into the word (first byte lands in [31:24]) and XORs into the accumulator. On the 4th byte of a word, the next cycle presents mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = the assembled word. The word index then increments.
- After word N-1 is accepted: DATA -> CSUM. That word's mem_we pulse still occurs.
- CSUM: accept byte.
  - Equal to accumulator -> DONE: busy=0, done=1, cpu_rst=0 (CPU restarts from PC 0).
  - Not equal -> ERR, err_code=2.
- Timeout: a counter clears on entry to HDR_HI and on every accepted byte, and increments on every other cycle in HDR_HI..CSUM. When it reaches TIMEOUT-1 -> ERR, err_code=3.
- ERR: busy=0, err=1, cpu_rst stays 1 (a CPU must not run a partial image). Only a new start or rst leaves ERR.
- mem_we never asserts outside DATA, except the one trailing pulse for the last word. There are no writes for bytes accepted in header or CSUM states.
- mem_addr wraps are impossible: N <= 2**MEM_AW is enforced.
- rx_valid with rx_ready=0: byte not consumed, no state change.
- Reset mid-load: everything returns to reset values immediately. Words already written stay in memory. cpu_rst drops to 0.
- Throughput: one byte per cycle when rx_valid is held high; an N-word load completes in 4N+3 accepted-byte cycles plus 1.

Test Plan:
- start; bytes 00 02 DE AD BE EF 01 23 45 67 then checksum (XOR of the 8 data bytes) -> mem_we pulses at addr 0 with DEADBEEF and addr 1 with 01234567; done=1, err=0, cpu_rst 1->0, busy 0.
- start; header 00 00 -> err=1, err_code=1, no mem_we, cpu_rst stays 1. Repeat with header 10 01 (4097), MEM_AW=12 -> same result.
- Valid 1-word load with wrong checksum byte -> mem_we once at addr 0, then err_code=2, cpu_rst=1. A following correct load -> done=1, err=0, cpu_rst=0.
- TIMEOUT=16: start, send 00 01 AA, then idle -> ERR with err_code=3 exactly 15 idle cycles after the last accepted byte; no mem_we.
- rx_valid toggling every other cycle with a 3-word load -> words written to addrs 0,1,2 with correct data; start pulsed during DATA is ignored.
- Assert rst during DATA after 1 word -> all outputs return to reset values asynchronously; the next start loads normally from addr 0.
